// File: rtl/spi_engine_pkg.sv
// Shared types and constants for the SPI byte engine.
package spi_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_e;

    localparam logic SPI_IDLE_MOSI = 1'b1;
    localparam logic SPI_IDLE_SCK  = 1'b0;

    localparam int PHASE_W = 4;
    localparam int BIT_W   = 3;

endpackage

// File: rtl/spi_byte_engine_sync_ff.sv
// Multi-flop synchroniser for an asynchronous level, with selectable reset value.
module sync_ff #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic MB_CLK,
    input  logic RESET,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] chain_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            chain_q <= {DEPTH{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = chain_q[DEPTH-1];

endmodule

// File: rtl/spi_byte_engine.sv
// Mode-0, MSB-first SPI master: one synchronised CPU write shifts one byte out and one in.
module spi_byte_engine
    import spi_engine_pkg::*;
#(
    parameter int HALF_PERIOD = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       MB_CLK,
    input  logic       RESET,
    input  logic       WR_REQ,
    input  logic [7:0] WR_DATA,
    input  logic       CS_REQ,
    input  logic       SPI_MISO,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    output logic       SPI_CS,
    output logic       BUSY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       OVERRUN
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = '1;

    logic wr_sync, cs_sync, wr_event;

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_wr_sync (
        .MB_CLK(MB_CLK), .RESET(RESET), .d_i(WR_REQ), .q_o(wr_sync)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .MB_CLK(MB_CLK), .RESET(RESET), .d_i(CS_REQ), .q_o(cs_sync)
    );

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    // Holds the seven tx bits still to send; received bits enter at the LSB as they go.
    logic [6:0]         shift_q, shift_d;
    logic               sample_q, sample_d;
    logic               sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d;
    logic               busy_q, busy_d, rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               wr_prev_q;

    assign wr_event = wr_sync & ~wr_prev_q;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        sample_d   = sample_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        overrun_d  = overrun_q;

        // Any write arriving outside IDLE, including on the done edge, is dropped.
        if (wr_event && state_q != IDLE) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                cs_d = cs_sync;
                if (wr_event) begin
                    shift_d   = WR_DATA[6:0];
                    mosi_d    = WR_DATA[7];
                    busy_d    = 1'b1;
                    overrun_d = 1'b0;
                    phase_d   = '0;
                    bit_d     = '0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                sck_d = SPI_IDLE_SCK;
                if (phase_q == PHASE_LAST) begin
                    sample_d = SPI_MISO;
                    sck_d    = 1'b1;
                    phase_d  = '0;
                    state_d  = HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            HIGH: begin
                sck_d = 1'b1;
                if (phase_q == PHASE_LAST) begin
                    sck_d   = SPI_IDLE_SCK;
                    phase_d = '0;
                    shift_d = {shift_q[5:0], sample_q};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        rx_data_d  = {shift_q, sample_q};
                        rx_valid_d = 1'b1;
                        busy_d     = 1'b0;
                        mosi_d     = SPI_IDLE_MOSI;
                        state_d    = IDLE;
                    end else begin
                        mosi_d  = shift_q[6];
                        state_d = LOW;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            sample_q   <= 1'b0;
            sck_q      <= SPI_IDLE_SCK;
            mosi_q     <= SPI_IDLE_MOSI;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            wr_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            sample_q   <= sample_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            wr_prev_q  <= wr_sync;
        end
    end

    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_CS   = cs_q;
    assign BUSY     = busy_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign OVERRUN  = overrun_q;

endmodule
